control_unit_frame: RTL and testbench

CONTROL_UNIT_FRAME -- requirements
Module: control_unit_frame

---
 rtl/control_unit_frame_if.sv | 32 +++
 rtl/control_unit_frame.sv | 182 ++++++++++++++++++
 tb/tb_control_unit_frame.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_frame_if.sv
// Stream interface between the word source and the frame control unit.
// master drives words in; slave (the control unit) returns buffer/filter controls.
interface control_unit_frame_if #(
   parameter int DATA_BIT   = 15,
   parameter int DATA_IDBIT = 2,
   parameter int CNT_BIT    = 10
);
   logic [DATA_IDBIT-1:0] data_id;
   logic                  data_in_valid;
   logic [DATA_BIT-1:0]   data_in;
   logic                  in_ready;
   logic                  ctrl2buf_valid;
   logic                  update_cf;
   logic [CNT_BIT-1:0]    cf_addr;
   logic                  en_funct;
   logic [DATA_BIT-1:0]   data_out;
   logic                  frame_done;
   logic                  cf_loaded;
   logic                  cf_err;

   modport master (
      output data_id, data_in_valid, data_in,
      input  in_ready, ctrl2buf_valid, update_cf, cf_addr, en_funct,
             data_out, frame_done, cf_loaded, cf_err
   );

   modport slave (
      input  data_id, data_in_valid, data_in,
      output in_ready, ctrl2buf_valid, update_cf, cf_addr, en_funct,
             data_out, frame_done, cf_loaded, cf_err
   );
endinterface

// File: rtl/control_unit_frame.sv
// Frame control unit: loads the coefficient file, walks pixels through a frame,
// flags interior pixels for the filter and drains the filter pipe at frame end.
module control_unit_frame #(
   parameter int DATA_BIT   = 15,
   parameter int DATA_IDBIT = 2,
   parameter int ROW_WIDTH  = 512,
   parameter int COL_WIDTH  = 512,
   parameter int MASK_WIDTH = 7,
   parameter int CNT_BIT    = 10,
   parameter int PIPE_DEPTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   control_unit_frame_if.slave bus
);
   localparam int HALF = (MASK_WIDTH - 1) / 2;
   localparam logic [CNT_BIT-1:0] X_LAST  = CNT_BIT'(ROW_WIDTH - 1);
   localparam logic [CNT_BIT-1:0] Y_LAST  = CNT_BIT'(COL_WIDTH - 1);
   localparam logic [CNT_BIT-1:0] EDGE    = CNT_BIT'(2 * HALF);
   localparam logic [CNT_BIT-1:0] CF_LAST = CNT_BIT'(MASK_WIDTH * MASK_WIDTH - 1);
   localparam logic [CNT_BIT-1:0] DRN_END = CNT_BIT'(PIPE_DEPTH);
   localparam logic [CNT_BIT-1:0] ONE     = CNT_BIT'(1);
   localparam logic [DATA_IDBIT-1:0] ID_PIX   = DATA_IDBIT'(0);
   localparam logic [DATA_IDBIT-1:0] ID_CF    = DATA_IDBIT'(1);
   localparam logic [DATA_IDBIT-1:0] ID_ABORT = DATA_IDBIT'(2);

   typedef enum logic [1:0] {IDLE, UPDT_CF, PROCESS, DRAIN} state_t;

   state_t              state, state_n;
   logic [CNT_BIT-1:0]  x_cnt, x_n, y_cnt, y_n, cf_cnt, cf_n, drn_cnt, drn_n;
   logic [CNT_BIT-1:0]  addr_q, addr_n;
   logic [DATA_BIT-1:0] dout_q, dout_n;
   logic                rdy_q, rdy_n, c2b_q, c2b_n, upd_q, upd_n, en_q, en_n;
   logic                fd_q, fd_n, ld_q, ld_n, err_q, err_n;
   logic                accept, pix;

   assign accept = bus.data_in_valid && rdy_q;

   always_comb begin
      state_n = state;
      x_n     = x_cnt;
      y_n     = y_cnt;
      cf_n    = cf_cnt;
      drn_n   = drn_cnt;
      addr_n  = addr_q;
      dout_n  = dout_q;
      ld_n    = ld_q;
      err_n   = err_q;
      c2b_n   = 1'b0;
      upd_n   = 1'b0;
      en_n    = 1'b0;
      fd_n    = 1'b0;
      pix     = 1'b0;

      if (accept) dout_n = bus.data_in;

      case (state)
         IDLE: if (accept) begin
            if (bus.data_id == ID_CF) begin
               upd_n   = 1'b1;
               addr_n  = '0;
               cf_n    = ONE;
               state_n = UPDT_CF;
            end else if (bus.data_id == ID_PIX) begin
               pix     = 1'b1;
               state_n = PROCESS;
            end
         end
         UPDT_CF: if (accept) begin
            case (bus.data_id)
               ID_CF: begin
                  upd_n  = 1'b1;
                  addr_n = cf_cnt;
                  if (cf_cnt == CF_LAST) begin
                     ld_n    = 1'b1;
                     cf_n    = '0;
                     state_n = IDLE;
                  end else begin
                     cf_n = cf_cnt + ONE;
                  end
               end
               ID_PIX: begin
                  err_n   = 1'b1;
                  cf_n    = '0;
                  state_n = IDLE;
               end
               ID_ABORT: begin
                  cf_n    = '0;
                  state_n = IDLE;
               end
               default: ;
            endcase
         end
         PROCESS: if (accept) begin
            case (bus.data_id)
               ID_PIX: pix = 1'b1;
               ID_CF:  err_n = 1'b1;
               ID_ABORT: begin
                  x_n     = '0;
                  y_n     = '0;
                  state_n = IDLE;
               end
               default: ;
            endcase
         end
         DRAIN: begin
            // one extra count beyond PIPE_DEPTH: frame_done lands 1+PIPE_DEPTH edges after the last pixel
            if (drn_cnt == DRN_END) begin
               fd_n    = 1'b1;
               drn_n   = '0;
               state_n = IDLE;
            end else begin
               drn_n = drn_cnt + ONE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (pix) begin
         c2b_n = 1'b1;
         en_n  = (x_cnt >= EDGE) && (y_cnt >= EDGE);
         if (x_cnt == X_LAST) begin
            x_n = '0;
            if (y_cnt == Y_LAST) begin
               y_n     = '0;
               drn_n   = '0;
               state_n = DRAIN;
            end else begin
               y_n = y_cnt + ONE;
            end
         end else begin
            x_n = x_cnt + ONE;
         end
      end

      rdy_n = (state_n != DRAIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         x_cnt   <= '0;
         y_cnt   <= '0;
         cf_cnt  <= '0;
         drn_cnt <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b1;
         c2b_q   <= 1'b0;
         upd_q   <= 1'b0;
         en_q    <= 1'b0;
         fd_q    <= 1'b0;
         ld_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         x_cnt   <= x_n;
         y_cnt   <= y_n;
         cf_cnt  <= cf_n;
         drn_cnt <= drn_n;
         addr_q  <= addr_n;
         dout_q  <= dout_n;
         rdy_q   <= rdy_n;
         c2b_q   <= c2b_n;
         upd_q   <= upd_n;
         en_q    <= en_n;
         fd_q    <= fd_n;
         ld_q    <= ld_n;
         err_q   <= err_n;
      end
   end

   assign bus.in_ready       = rdy_q;
   assign bus.ctrl2buf_valid = c2b_q;
   assign bus.update_cf      = upd_q;
   assign bus.cf_addr        = addr_q;
   assign bus.en_funct       = en_q;
   assign bus.data_out       = dout_q;
   assign bus.frame_done     = fd_q;
   assign bus.cf_loaded      = ld_q;
   assign bus.cf_err         = err_q;
endmodule

// File: tb/tb_control_unit_frame.sv
// Directed bench for control_unit_frame on an 8x8 frame with a 3x3 mask.
module tb_control_unit_frame;
   localparam int DB = 15, IB = 2, RW = 8, CW = 8, MW = 3, CB = 10, PD = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   control_unit_frame_if #(.DATA_BIT(DB), .DATA_IDBIT(IB), .CNT_BIT(CB)) bus ();

   control_unit_frame #(
      .DATA_BIT(DB), .DATA_IDBIT(IB), .ROW_WIDTH(RW), .COL_WIDTH(CW),
      .MASK_WIDTH(MW), .CNT_BIT(CB), .PIPE_DEPTH(PD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_chk = 0, n_fail = 0;
   int cnt_cb = 0, cnt_en = 0, cnt_fd = 0;
   int f_cb, f_en, f_fd, f_first, f_gap, f_lat, f_irlow;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [IB-1:0] id, input logic [DB-1:0] d);
      bus.data_in_valid = v;
      bus.data_id       = id;
      bus.data_in       = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cnt_cb += int'(bus.ctrl2buf_valid);
      cnt_en += int'(bus.en_funct);
      cnt_fd += int'(bus.frame_done);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_flags"}, 32'({bus.in_ready, bus.ctrl2buf_valid, bus.update_cf, bus.en_funct,
                                bus.frame_done, bus.cf_loaded, bus.cf_err}), 32'b1000000);
      chk({tag, "_addr"}, 32'(bus.cf_addr), 32'd0);
      chk({tag, "_dout"}, 32'(bus.data_out), 32'd0);
   endtask

   // Drives one frame of pixels (value = raster index); optional gap and abort.
   task automatic frame(input int gap_at, input int gap_len, input int abort_at);
      int cb0, en0, fd0;
      cb0 = cnt_cb; en0 = cnt_en; fd0 = cnt_fd;
      f_first = -1; f_gap = 0; f_lat = 0; f_irlow = 0;
      for (int p = 0; p < RW * CW; p++) begin
         if (p == abort_at) begin
            drive(1'b1, 2'd2, '0);
            step();
            break;
         end
         if (p == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(1'b0, 2'd0, '0);
               step();
               f_gap += int'(bus.ctrl2buf_valid) + int'(bus.en_funct);
            end
         end
         drive(1'b1, 2'd0, DB'(p));
         step();
         if (bus.en_funct && f_first < 0) f_first = p;
      end
      drive(1'b0, 2'd0, '0);
      if (abort_at < 0) begin
         if (!bus.in_ready) f_irlow++;
         for (int t = 1; t <= 20; t++) begin
            step();
            f_lat = t;
            if (bus.frame_done) break;
            if (!bus.in_ready) f_irlow++;
         end
      end else begin
         for (int t = 0; t < 10; t++) step();
      end
      f_cb = cnt_cb - cb0;
      f_en = cnt_en - en0;
      f_fd = cnt_fd - fd0;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 2'd0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst0");
      reset = 1'b1;
      step();

      // full coefficient load, back to back
      for (int i = 0; i < MW * MW; i++) begin
         drive(1'b1, 2'd1, DB'(100 + i));
         step();
         chk("ld_upd", 32'(bus.update_cf), 32'd1);
         chk("ld_addr", 32'(bus.cf_addr), 32'(i));
         chk("ld_dout", 32'(bus.data_out), 32'(100 + i));
      end
      chk("ld_loaded", 32'(bus.cf_loaded), 32'd1);
      drive(1'b0, 2'd0, '0);
      step();
      chk("ld_idle_upd", 32'(bus.update_cf), 32'd0);
      chk("ld_idle_rdy", 32'(bus.in_ready), 32'd1);

      // gapless frame
      frame(-1, 0, -1);
      chk("f1_cb", 32'(f_cb), 32'd64);
      chk("f1_en", 32'(f_en), 32'd36);
      chk("f1_first_en", 32'(f_first), 32'd18);
      chk("f1_fd", 32'(f_fd), 32'd1);
      chk("f1_lat", 32'(f_lat), 32'(1 + PD));
      chk("f1_irlow", 32'(f_irlow), 32'(1 + PD));

      // frame with a 3-cycle hole at pixel 20
      frame(20, 3, -1);
      chk("f2_cb", 32'(f_cb), 32'd64);
      chk("f2_en", 32'(f_en), 32'd36);
      chk("f2_gap", 32'(f_gap), 32'd0);
      chk("f2_fd", 32'(f_fd), 32'd1);
      chk("f2_lat", 32'(f_lat), 32'(1 + PD));

      // abort after pixel 30, then a clean frame
      frame(-1, 0, 31);
      chk("ab_cb", 32'(f_cb), 32'd31);
      chk("ab_en", 32'(f_en), 32'd11);
      chk("ab_fd", 32'(f_fd), 32'd0);
      frame(-1, 0, -1);
      chk("f3_cb", 32'(f_cb), 32'd64);
      chk("f3_en", 32'(f_en), 32'd36);
      chk("f3_first_en", 32'(f_first), 32'd18);
      chk("f3_fd", 32'(f_fd), 32'd1);

      // coefficient and reserved words inside a frame
      drive(1'b1, 2'd0, DB'(5));
      step();
      drive(1'b1, 2'd1, DB'(7));
      step();
      chk("pc_err", 32'(bus.cf_err), 32'd1);
      chk("pc_upd", 32'(bus.update_cf), 32'd0);
      chk("pc_c2b", 32'(bus.ctrl2buf_valid), 32'd0);
      chk("pc_dout", 32'(bus.data_out), 32'd7);
      drive(1'b1, 2'd3, DB'(9));
      step();
      chk("pr_c2b", 32'(bus.ctrl2buf_valid), 32'd0);
      drive(1'b1, 2'd2, '0);
      step();
      drive(1'b0, 2'd0, '0);
      step();

      // reset clears sticky state
      reset = 1'b0;
      #1;
      chk_reset("rst1");
      step();
      reset = 1'b1;
      step();

      // pixel interrupts a load after 4 coefficients
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'd1, DB'(200 + i));
         step();
         chk("pl_addr", 32'(bus.cf_addr), 32'(i));
      end
      drive(1'b1, 2'd0, DB'(55));
      step();
      chk("pl_upd", 32'(bus.update_cf), 32'd0);
      chk("pl_c2b", 32'(bus.ctrl2buf_valid), 32'd0);
      chk("pl_err", 32'(bus.cf_err), 32'd1);
      chk("pl_loaded", 32'(bus.cf_loaded), 32'd0);
      for (int i = 0; i < MW * MW; i++) begin
         if (i == 5) begin
            drive(1'b0, 2'd0, '0);
            step();
            chk("rl_stall_upd", 32'(bus.update_cf), 32'd0);
         end
         drive(1'b1, 2'd1, DB'(300 + i));
         step();
         chk("rl_upd", 32'(bus.update_cf), 32'd1);
         chk("rl_addr", 32'(bus.cf_addr), 32'(i));
      end
      chk("rl_loaded", 32'(bus.cf_loaded), 32'd1);
      chk("rl_err", 32'(bus.cf_err), 32'd1);
      drive(1'b0, 2'd0, '0);
      step();

      // reset in the middle of DRAIN
      for (int p = 0; p < RW * CW; p++) begin
         drive(1'b1, 2'd0, DB'(p));
         step();
      end
      drive(1'b0, 2'd0, '0);
      step();
      step();
      chk("md_rdy_before", 32'(bus.in_ready), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk_reset("rst2");
      begin
         int fd0;
         fd0 = cnt_fd;
         repeat (3) step();
         reset = 1'b1;
         for (int t = 0; t < 10; t++) step();
         chk("md_no_fd", 32'(cnt_fd - fd0), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
